// File: rtl/mem_wb_sequencer.sv
// Memory-access / write-back sequencer: one instruction at a time through IDLE -> MEM -> WB,
// with alignment and timeout faults, registered load data and a single-cycle register write.
module mem_wb_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        wb_en,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] dmem_out_q,
  output logic        mem_to_reg,
  output logic [6:0]  load_type,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_WB,
    ST_FAULT
  } state_t;

  state_t        state_q;
  logic          is_load_q;
  logic          wb_en_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] wait_q;

  logic          mem_op_d;
  logic          misaligned_d;
  logic [31:0]   wdata_d;
  logic [3:0]    wmask_d;
  logic [6:0]    load_type_d;

  // Decode of the instruction presented at start; only consumed when it is accepted.
  always_comb begin
    mem_op_d     = is_load | is_store;
    misaligned_d = 1'b0;
    wdata_d      = store_data;
    wmask_d      = 4'b1111;
    load_type_d  = 7'd7;
    case (size)
      2'd0: begin
        wdata_d     = {4{store_data[7:0]}};
        wmask_d     = 4'b0001 << addr[1:0];
        load_type_d = 7'({is_unsigned, 1'b0, addr[1:0]});
      end
      2'd1: begin
        misaligned_d = addr[0];
        wdata_d      = {2{store_data[15:0]}};
        wmask_d      = addr[1] ? 4'b1100 : 4'b0011;
        if (is_unsigned) begin
          load_type_d = addr[1] ? 7'd13 : 7'd12;
        end else begin
          load_type_d = addr[1] ? 7'd6 : 7'd4;
        end
      end
      default: begin
        misaligned_d = (addr[1:0] != 2'b00);
      end
    endcase
    if (!is_load) begin
      load_type_d = 7'd7;
    end
    if (!is_store) begin
      wdata_d = '0;
      wmask_d = '0;
    end
  end

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_load_q  <= 1'b0;
      wb_en_q    <= 1'b0;
      rd_q       <= '0;
      wait_q     <= '0;
      done       <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wmask <= '0;
      dmem_out_q <= '0;
      mem_to_reg <= 1'b0;
      load_type  <= 7'd7;
      reg_we     <= 1'b0;
      reg_waddr  <= '0;
      fault      <= 1'b0;
      fault_code <= 2'd0;
    end else begin
      done   <= 1'b0;
      fault  <= 1'b0;
      reg_we <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_load_q  <= is_load;
            wb_en_q    <= wb_en;
            rd_q       <= rd;
            wait_q     <= '0;
            fault_code <= 2'd0;
            mem_to_reg <= 1'b0;
            load_type  <= load_type_d;
            if (mem_op_d && misaligned_d) begin
              state_q    <= ST_FAULT;
              fault      <= 1'b1;
              done       <= 1'b1;
              fault_code <= 2'd1;
            end else if (mem_op_d) begin
              state_q    <= ST_MEM;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= addr[31:2];
              dmem_wdata <= wdata_d;
              dmem_wmask <= wmask_d;
            end else begin
              state_q   <= ST_WB;
              done      <= 1'b1;
              reg_we    <= wb_en && (rd != 5'd0);
              reg_waddr <= rd;
            end
          end
        end
        ST_MEM: begin
          if (dmem_ready || (wait_q == WAIT_LAST)) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wmask <= '0;
          end
          // A completion in the last allowed cycle takes priority over the timeout.
          if (dmem_ready) begin
            if (is_load_q) begin
              dmem_out_q <= dmem_rdata;
            end
            state_q    <= ST_WB;
            done       <= 1'b1;
            reg_we     <= (is_load_q || wb_en_q) && (rd_q != 5'd0);
            reg_waddr  <= rd_q;
            mem_to_reg <= is_load_q;
          end else if (wait_q == WAIT_LAST) begin
            state_q    <= ST_FAULT;
            fault      <= 1'b1;
            done       <= 1'b1;
            fault_code <= 2'd2;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        ST_WB: begin
          state_q <= ST_IDLE;
        end
        ST_FAULT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_sequencer.sv
// Self-checking bench for mem_wb_sequencer: directed scenarios plus randomized transactions
// checked against a latency/formatting model derived from the instruction rules.
module tb_mem_wb_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic        wb_en;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] dmem_out_q;
  logic        mem_to_reg;
  logic [6:0]  load_type;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic        fault;
  logic [1:0]  fault_code;

  int passed = 0;
  int total  = 0;

  // Observations gathered by run_txn
  int          obs_req_cycles;
  int          obs_first_req;
  int          obs_done_cycle;
  logic        obs_held_ok;
  logic [29:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_wmask;
  logic        obs_we;
  logic        obs_reg_we;
  logic [4:0]  obs_waddr;
  logic        obs_m2r;
  logic [6:0]  obs_lt;
  logic        obs_fault;
  logic [1:0]  obs_fcode;
  logic        obs_busy_after;
  logic [6:0]  obs_lt_after;
  logic        obs_m2r_after;
  logic [1:0]  obs_fcode_after;
  logic [31:0] obs_out_after;
  logic        ready_noise = 1'b0;
  logic [31:0] model_out_q;

  mem_wb_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
    .wb_en(wb_en), .size(size), .is_unsigned(is_unsigned), .addr(addr),
    .store_data(store_data), .rd(rd), .busy(busy), .done(done), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_out_q(dmem_out_q), .mem_to_reg(mem_to_reg), .load_type(load_type),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int width_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic model_misaligned(input logic ld, input logic st,
                                            input logic [1:0] sz, input logic [31:0] a);
    return (ld || st) && ((int'(a[1:0]) % width_of(sz)) != 0);
  endfunction

  function automatic logic [3:0] model_wmask(input logic [1:0] sz, input logic [31:0] a);
    int w;
    w = width_of(sz);
    return 4'(((1 << w) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] sd);
    logic [31:0] r;
    int w;
    w = width_of(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % w) +: 8];
    return r;
  endfunction

  function automatic logic [6:0] model_load_type(input logic ld, input logic [1:0] sz,
                                                 input logic uns, input logic [31:0] a);
    int lane;
    int w;
    lane = int'(a[1:0]);
    w    = width_of(sz);
    if (!ld || w == 4) return 7'd7;
    if (w == 1) return uns ? 7'(8 + lane) : 7'(lane);
    return uns ? 7'(12 + lane / 2) : 7'(4 + lane);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic ld, input logic st, input logic wen, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input int waits, input logic [31:0] rdata);
    int lowcnt;
    is_load = ld; is_store = st; wb_en = wen; size = sz; is_unsigned = uns;
    addr = a; store_data = sd; rd = r; start = 1'b1;
    step();
    start = 1'b0;
    obs_req_cycles = 0; obs_first_req = -1; obs_done_cycle = -1; obs_held_ok = 1'b1;
    obs_addr = '0; obs_wdata = '0; obs_wmask = '0; obs_we = 1'b0;
    obs_reg_we = 1'b0; obs_waddr = '0; obs_m2r = 1'b0; obs_lt = '0; obs_fault = 1'b0;
    obs_fcode = '0;
    lowcnt = 0;
    for (int c = 1; c <= 60 && obs_done_cycle < 0; c++) begin
      if (dmem_req) begin
        if (obs_req_cycles == 0) begin
          obs_first_req = c; obs_addr = dmem_addr; obs_wdata = dmem_wdata;
          obs_wmask = dmem_wmask; obs_we = dmem_we;
        end else if ({dmem_addr, dmem_wdata, dmem_wmask, dmem_we} !==
                     {obs_addr, obs_wdata, obs_wmask, obs_we}) begin
          obs_held_ok = 1'b0;
        end
        obs_req_cycles++;
      end
      if (done) begin
        obs_done_cycle = c; obs_reg_we = reg_we; obs_waddr = reg_waddr; obs_m2r = mem_to_reg;
        obs_lt = load_type; obs_fault = fault; obs_fcode = fault_code;
      end
      if (dmem_req && waits >= 0 && lowcnt >= waits) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
      end else begin
        dmem_ready = dmem_req ? 1'b0 : (ready_noise & 1'($urandom_range(1)));
        dmem_rdata = $urandom;
        if (dmem_req) lowcnt++;
      end
      if (obs_done_cycle < 0) step();
    end
    dmem_ready = 1'b0;
    step();
    obs_busy_after = busy; obs_lt_after = load_type; obs_m2r_after = mem_to_reg;
    obs_fcode_after = fault_code; obs_out_after = dmem_out_q;
    $display("txn ld=%0b st=%0b wen=%0b size=%0d addr=%h rd=%0d waits=%0d -> done@%0d req_cycles=%0d fault_code=%0d reg_we=%0b",
             ld, st, wen, sz, a, r, waits, obs_done_cycle, obs_req_cycles, obs_fcode, obs_reg_we);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [111:0] rest;
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; wb_en = 1'b0; size = '0;
    is_unsigned = 1'b0; addr = '0; store_data = '0; rd = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    step(); step(); step();
    rest = {busy, done, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask, dmem_out_q,
            mem_to_reg, reg_we, reg_waddr, fault, fault_code};
    total++; if (rest !== '0) $display("FAIL reset_zero: got %h required 0", rest); else passed++;
    total++; if (load_type !== 7'd7) $display("FAIL reset_load_type: got %0d required 7", load_type); else passed++;
    reset = 1'b0;
    step();
    $display("txn reset sequence complete");
  endtask

  task automatic test_load_byte();
    run_txn(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_1002, 32'h0, 5'd9, 0, 32'h80FF_0000);
    total++; if (obs_first_req !== 1) $display("FAIL lb_first_req: got %0d required 1", obs_first_req); else passed++;
    total++; if (obs_req_cycles !== 1) $display("FAIL lb_req_cycles: got %0d required 1", obs_req_cycles); else passed++;
    total++; if (obs_addr !== 30'h400) $display("FAIL lb_addr: got %h required 400", obs_addr); else passed++;
    total++; if (obs_done_cycle !== 2) $display("FAIL lb_done_cycle: got %0d required 2", obs_done_cycle); else passed++;
    total++; if ({obs_reg_we, obs_waddr} !== {1'b1, 5'd9}) $display("FAIL lb_reg_we: got %b/%0d required 1/9", obs_reg_we, obs_waddr); else passed++;
    total++; if ({obs_m2r, obs_lt} !== {1'b1, 7'd2}) $display("FAIL lb_m2r_lt: got %b/%0d required 1/2", obs_m2r, obs_lt); else passed++;
    total++; if (obs_out_after !== 32'h80FF_0000) $display("FAIL lb_out_q: got %h required 80ff0000", obs_out_after); else passed++;
    total++; if (obs_busy_after !== 1'b0) $display("FAIL lb_idle: got busy=%b required 0", obs_busy_after); else passed++;
  endtask

  task automatic test_half_store_wait();
    run_txn(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h1234_ABCD, 5'd4, 3, 32'hDEAD_BEEF);
    total++; if (obs_req_cycles !== 4) $display("FAIL sh_req_cycles: got %0d required 4", obs_req_cycles); else passed++;
    total++; if (obs_held_ok !== 1'b1) $display("FAIL sh_held: got %b required 1", obs_held_ok); else passed++;
    total++; if ({obs_we, obs_wdata, obs_wmask} !== {1'b1, 32'hABCD_ABCD, 4'b1100}) $display("FAIL sh_lanes: got we=%b wdata=%h wmask=%b required 1/abcdabcd/1100", obs_we, obs_wdata, obs_wmask); else passed++;
    total++; if (obs_done_cycle !== 5) $display("FAIL sh_done_cycle: got %0d required 5", obs_done_cycle); else passed++;
    total++; if (obs_reg_we !== 1'b0) $display("FAIL sh_reg_we: got %b required 0", obs_reg_we); else passed++;
    total++; if (obs_out_after !== 32'h80FF_0000) $display("FAIL sh_out_q_kept: got %h required 80ff0000", obs_out_after); else passed++;
  endtask

  task automatic test_misaligned();
    run_txn(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0003, 32'h0, 5'd3, 0, 32'h1111_2222);
    total++; if (obs_req_cycles !== 0) $display("FAIL mis_req: got %0d required 0", obs_req_cycles); else passed++;
    total++; if ({obs_done_cycle, obs_fault, obs_fcode} !== {32'sd1, 1'b1, 2'd1}) $display("FAIL mis_fault: got done@%0d fault=%b code=%0d required 1/1/1", obs_done_cycle, obs_fault, obs_fcode); else passed++;
    total++; if (obs_reg_we !== 1'b0) $display("FAIL mis_reg_we: got %b required 0", obs_reg_we); else passed++;
    total++; if ({obs_busy_after, obs_fcode_after} !== {1'b0, 2'd1}) $display("FAIL mis_after: got busy=%b code=%0d required 0/1", obs_busy_after, obs_fcode_after); else passed++;
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 5'd6, -1, 32'h0);
    total++; if (obs_req_cycles !== TO) $display("FAIL to_req_cycles: got %0d required %0d", obs_req_cycles, TO); else passed++;
    total++; if (obs_done_cycle !== TO + 1) $display("FAIL to_done_cycle: got %0d required %0d", obs_done_cycle, TO + 1); else passed++;
    total++; if ({obs_fault, obs_fcode, obs_reg_we} !== {1'b1, 2'd2, 1'b0}) $display("FAIL to_fault: got fault=%b code=%0d reg_we=%b required 1/2/0", obs_fault, obs_fcode, obs_reg_we); else passed++;
  endtask

  task automatic test_unsigned_half_rd0();
    run_txn(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 5'd0, 1, 32'hCAFE_0123);
    total++; if (obs_lt !== 7'd13) $display("FAIL lhu_load_type: got %0d required 13", obs_lt); else passed++;
    total++; if ({obs_done_cycle, obs_reg_we} !== {32'sd3, 1'b0}) $display("FAIL lhu_rd0: got done@%0d reg_we=%b required 3/0", obs_done_cycle, obs_reg_we); else passed++;
    total++; if ({obs_lt_after, obs_m2r_after} !== {7'd13, 1'b1}) $display("FAIL lhu_stable: got lt=%0d m2r=%b required 13/1", obs_lt_after, obs_m2r_after); else passed++;
    run_txn(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 5'd17, 0, 32'h0BAD_0001);
    total++; if ({obs_reg_we, obs_waddr} !== {1'b1, 5'd17}) $display("FAIL lhu_rd17: got %b/%0d required 1/17", obs_reg_we, obs_waddr); else passed++;
  endtask

  task automatic test_reset_mid_mem();
    logic [111:0] rest;
    logic bad;
    is_load = 1'b1; is_store = 1'b0; wb_en = 1'b0; size = 2'd2; addr = 32'h0000_0080; rd = 5'd5;
    start = 1'b1;
    step();
    start = 1'b0; dmem_ready = 1'b0;
    step();
    total++; if (dmem_req !== 1'b1) $display("FAIL rst_mem_req_before: got %b required 1", dmem_req); else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rest = {busy, done, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask, dmem_out_q,
            mem_to_reg, reg_we, reg_waddr, fault, fault_code};
    total++; if (rest !== '0) $display("FAIL rst_mid_zero: got %h required 0", rest); else passed++;
    total++; if (load_type !== 7'd7) $display("FAIL rst_mid_load_type: got %0d required 7", load_type); else passed++;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      dmem_ready = 1'b1;
      if (done || reg_we || dmem_req) bad = 1'b1;
      step();
    end
    dmem_ready = 1'b0;
    total++; if (bad !== 1'b0) $display("FAIL rst_mid_no_wb: got activity=%b required 0", bad); else passed++;
    $display("txn reset during MEM complete");
  endtask

  task automatic test_busy_start();
    int reqs;
    int dones;
    int lowc;
    logic addr_ok;
    is_load = 1'b1; is_store = 1'b0; wb_en = 1'b0; size = 2'd2; is_unsigned = 1'b0;
    addr = 32'h0000_0100; rd = 5'd12; start = 1'b1;
    step();
    addr = 32'h0000_0200; rd = 5'd13;
    reqs = 0; dones = 0; lowc = 0; addr_ok = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (dmem_req) begin
        reqs++;
        if (dmem_addr !== 30'h40) addr_ok = 1'b0;
      end
      if (done) begin
        dones++;
        start = 1'b0;
      end
      dmem_ready = dmem_req && (lowc >= 2);
      dmem_rdata = 32'h5A5A_0F0F;
      if (dmem_req && !dmem_ready) lowc++;
      step();
    end
    start = 1'b0; dmem_ready = 1'b0;
    total++; if ({reqs, dones} !== {32'sd3, 32'sd1}) $display("FAIL busy_start: got req_cycles=%0d dones=%0d required 3/1", reqs, dones); else passed++;
    total++; if (addr_ok !== 1'b1) $display("FAIL busy_addr: got ok=%b required 1", addr_ok); else passed++;
    $display("txn busy-time start sequence complete");
  endtask

  task automatic test_random();
    logic ld, st, wen, uns, mis, tmo, mem, efault, erwe;
    logic [1:0] sz, ecode;
    logic [31:0] a, sd, rdata;
    logic [4:0] r;
    int waits, kind, edone, ereq, w;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_out_q = '0;
    ready_noise = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(2));
      ld = (kind == 0); st = (kind == 1);
      wen = 1'($urandom_range(1)); uns = 1'($urandom_range(1));
      sz = 2'($urandom_range(3)); w = width_of(sz);
      a = $urandom;
      if ($urandom_range(3) != 0) a = a & ~32'(w - 1);
      sd = $urandom; rdata = $urandom; r = 5'($urandom_range(31));
      waits = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(TO + 1));
      mem = ld || st;
      mis = model_misaligned(ld, st, sz, a);
      tmo = mem && !mis && (waits < 0 || waits >= TO);
      edone = (!mem || mis) ? 1 : (tmo ? TO + 1 : waits + 2);
      ereq = (!mem || mis) ? 0 : (tmo ? TO : waits + 1);
      efault = mis || tmo;
      ecode = mis ? 2'd1 : (tmo ? 2'd2 : 2'd0);
      erwe = !efault && (ld || wen) && (r != 5'd0);
      if (ld && !efault) model_out_q = rdata;
      run_txn(ld, st, wen, sz, uns, a, sd, r, waits, rdata);
      total++; if (obs_done_cycle !== edone) $display("FAIL rnd%0d_done_cycle: got %0d required %0d", n, obs_done_cycle, edone); else passed++;
      total++; if (obs_req_cycles !== ereq) $display("FAIL rnd%0d_req_cycles: got %0d required %0d", n, obs_req_cycles, ereq); else passed++;
      total++; if ({obs_fault, obs_fcode, obs_fcode_after} !== {efault, ecode, ecode}) $display("FAIL rnd%0d_fault: got %b/%0d/%0d required %b/%0d", n, obs_fault, obs_fcode, obs_fcode_after, efault, ecode); else passed++;
      total++; if (obs_reg_we !== erwe) $display("FAIL rnd%0d_reg_we: got %b required %b", n, obs_reg_we, erwe); else passed++;
      total++; if (obs_out_after !== model_out_q) $display("FAIL rnd%0d_out_q: got %h required %h", n, obs_out_after, model_out_q); else passed++;
      total++; if (obs_busy_after !== 1'b0) $display("FAIL rnd%0d_idle: got busy=%b required 0", n, obs_busy_after); else passed++;
      if (!efault) begin
        total++; if ({obs_lt, obs_lt_after} !== {2{model_load_type(ld, sz, uns, a)}}) $display("FAIL rnd%0d_load_type: got %0d/%0d required %0d", n, obs_lt, obs_lt_after, model_load_type(ld, sz, uns, a)); else passed++;
        total++; if ({obs_m2r, obs_waddr} !== {ld, r}) $display("FAIL rnd%0d_wb_fields: got m2r=%b waddr=%0d required %b/%0d", n, obs_m2r, obs_waddr, ld, r); else passed++;
      end
      if (mem && !mis) begin
        total++; if ({obs_addr, obs_we, obs_held_ok} !== {a[31:2], st, 1'b1}) $display("FAIL rnd%0d_req_fields: got addr=%h we=%b held=%b required %h/%b/1", n, obs_addr, obs_we, obs_held_ok, a[31:2], st); else passed++;
      end
      if (st && !mis) begin
        total++; if ({obs_wdata, obs_wmask} !== {model_wdata(sz, sd), model_wmask(sz, a)}) $display("FAIL rnd%0d_lanes: got %h/%b required %h/%b", n, obs_wdata, obs_wmask, model_wdata(sz, sd), model_wmask(sz, a)); else passed++;
      end
    end
    ready_noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_half_store_wait();
    test_misaligned();
    test_timeout();
    test_unsigned_half_rd0();
    test_reset_mid_mem();
    test_busy_start();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
